// File: rtl/sprite_line_renderer_if.sv
// Signal bundle for sprite_line_renderer: attribute writes, scanline control,
// sprite memory read port and the registered pixel result.
interface sprite_line_renderer_if;
   logic        attr_we;
   logic [2:0]  attr_addr;
   logic [31:0] attr_wdata;
   logic        line_start;
   logic [8:0]  line_y;
   logic [8:0]  mem_raddr;
   logic [31:0] mem_rdata;
   logic [9:0]  pix_x;
   logic        pix_hit;
   logic [1:0]  pix_color;
   logic [1:0]  pix_pal;
   logic        busy;
   logic        overflow;

   modport master (
      output attr_we, attr_addr, attr_wdata, line_start, line_y, mem_rdata, pix_x,
      input  mem_raddr, pix_hit, pix_color, pix_pal, busy, overflow
   );

   modport slave (
      input  attr_we, attr_addr, attr_wdata, line_start, line_y, mem_rdata, pix_x,
      output mem_raddr, pix_hit, pix_color, pix_pal, busy, overflow
   );
endinterface

// File: rtl/sprite_line_renderer.sv
// Scanline sprite engine: during hblank it scans the attribute table, fetches the
// row data of visible sprites into a pending slot set, then shows the active set.
module sprite_line_renderer #(
   parameter int MAX_SLOTS   = 4,
   parameter int NUM_SPRITES = 8
) (
   input logic                   clk,
   input logic                   reset,
   sprite_line_renderer_if.slave bus
);
   localparam int SEL_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int IDX_W  = $clog2(NUM_SPRITES + 1);
   localparam int CNT_W  = $clog2(MAX_SLOTS + 1);
   localparam int SLOT_W = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EVAL    = 2'd1,
      READ    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   // attribute table
   logic [9:0]  attr_x_r     [NUM_SPRITES];
   logic [8:0]  attr_y_r     [NUM_SPRITES];
   logic [4:0]  attr_tile_r  [NUM_SPRITES];
   logic [1:0]  attr_pal_r   [NUM_SPRITES];
   logic        attr_hflip_r [NUM_SPRITES];
   logic        attr_en_r    [NUM_SPRITES];

   // pending and active slot sets
   logic        pend_valid_r [MAX_SLOTS];
   logic [9:0]  pend_x_r     [MAX_SLOTS];
   logic [1:0]  pend_pal_r   [MAX_SLOTS];
   logic        pend_hflip_r [MAX_SLOTS];
   logic [31:0] pend_data_r  [MAX_SLOTS];
   logic        act_valid_r  [MAX_SLOTS];
   logic [9:0]  act_x_r      [MAX_SLOTS];
   logic [1:0]  act_pal_r    [MAX_SLOTS];
   logic        act_hflip_r  [MAX_SLOTS];
   logic [31:0] act_data_r   [MAX_SLOTS];
   logic [CNT_W-1:0] pend_cnt_r;
   logic        pend_ovf_r;
   logic        overflow_r;

   state_t            state_r;
   state_t            state_next_s;
   logic [IDX_W-1:0]  idx_r;
   logic [IDX_W-1:0]  idx_next_s;
   logic [8:0]        line_y_r;
   logic [8:0]        mem_raddr_r;
   logic              busy_r;
   logic              raddr_load_s;
   logic              capture_s;
   logic              ovf_set_s;

   logic [SEL_W-1:0]  cur_s;
   logic              idx_valid_s;
   logic [8:0]        row_s;
   logic              hit_s;
   logic              slot_free_s;
   logic [SLOT_W-1:0] slot_s;

   logic [9:0]  dx_s     [MAX_SLOTS];
   logic [3:0]  p_s      [MAX_SLOTS];
   logic [1:0]  col_s    [MAX_SLOTS];
   logic        opaque_s [MAX_SLOTS];
   logic        hit_nx_s;
   logic [1:0]  color_nx_s;
   logic [1:0]  pal_nx_s;
   logic        pix_hit_r;
   logic [1:0]  pix_color_r;
   logic [1:0]  pix_pal_r;

   // bits 30:27 of an attribute word carry no field
   logic unused_attr_bits_s;
   assign unused_attr_bits_s = ^bus.attr_wdata[30:27];

   // Attribute enables: cleared by reset, writable in any FSM state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_SPRITES; k++) begin
            attr_en_r[k] <= 1'b0;
         end
      end else if (bus.attr_we) begin
         attr_en_r[bus.attr_addr[SEL_W-1:0]] <= bus.attr_wdata[31];
      end
   end

   // Attribute payload fields; only meaningful once the enable is set
   always_ff @(posedge clk) begin
      if (bus.attr_we) begin
         attr_x_r[bus.attr_addr[SEL_W-1:0]]     <= bus.attr_wdata[9:0];
         attr_y_r[bus.attr_addr[SEL_W-1:0]]     <= bus.attr_wdata[18:10];
         attr_tile_r[bus.attr_addr[SEL_W-1:0]]  <= bus.attr_wdata[23:19];
         attr_pal_r[bus.attr_addr[SEL_W-1:0]]   <= bus.attr_wdata[25:24];
         attr_hflip_r[bus.attr_addr[SEL_W-1:0]] <= bus.attr_wdata[26];
      end
   end

   assign cur_s       = idx_r[SEL_W-1:0];
   assign idx_valid_s = (idx_r < IDX_W'(NUM_SPRITES));
   assign row_s       = line_y_r - attr_y_r[cur_s];
   assign hit_s       = idx_valid_s && attr_en_r[cur_s] && (row_s[8:4] == 5'd0);
   assign slot_free_s = (pend_cnt_r < CNT_W'(MAX_SLOTS));
   assign slot_s      = pend_cnt_r[SLOT_W-1:0];

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state and control strobes; line_start restarts from any state
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      raddr_load_s = 1'b0;
      capture_s    = 1'b0;
      ovf_set_s    = 1'b0;
      if (bus.line_start) begin
         state_next_s = EVAL;
         idx_next_s   = {IDX_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               state_next_s = IDLE;
            end
            EVAL: begin
               // one extra EVAL cycle with the index past the table ends the pass
               if (!idx_valid_s) begin
                  state_next_s = IDLE;
               end else if (hit_s && slot_free_s) begin
                  raddr_load_s = 1'b1;
                  state_next_s = READ;
               end else begin
                  ovf_set_s  = hit_s;
                  idx_next_s = idx_r + IDX_W'(1'b1);
               end
            end
            READ: begin
               state_next_s = CAPTURE;
            end
            CAPTURE: begin
               capture_s    = 1'b1;
               idx_next_s   = idx_r + IDX_W'(1'b1);
               state_next_s = EVAL;
            end
            default: begin
               state_next_s = IDLE;
            end
         endcase
      end
   end

   // Scan index, sampled scanline, memory address and busy flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_r       <= {IDX_W{1'b0}};
         line_y_r    <= 9'd0;
         mem_raddr_r <= 9'd0;
         busy_r      <= 1'b0;
      end else begin
         idx_r  <= idx_next_s;
         busy_r <= (state_next_s != IDLE);
         if (bus.line_start) begin
            line_y_r <= bus.line_y;
         end
         if (raddr_load_s) begin
            mem_raddr_r <= {attr_tile_r[cur_s], row_s[3:0]};
         end
      end
   end

   // Slot sets: swap on line_start, otherwise fill pending in sprite order
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_cnt_r <= {CNT_W{1'b0}};
         pend_ovf_r <= 1'b0;
         overflow_r <= 1'b0;
         for (int k = 0; k < MAX_SLOTS; k++) begin
            pend_valid_r[k] <= 1'b0;
            pend_x_r[k]     <= 10'd0;
            pend_pal_r[k]   <= 2'd0;
            pend_hflip_r[k] <= 1'b0;
            pend_data_r[k]  <= 32'd0;
            act_valid_r[k]  <= 1'b0;
            act_x_r[k]      <= 10'd0;
            act_pal_r[k]    <= 2'd0;
            act_hflip_r[k]  <= 1'b0;
            act_data_r[k]   <= 32'd0;
         end
      end else if (bus.line_start) begin
         pend_cnt_r <= {CNT_W{1'b0}};
         pend_ovf_r <= 1'b0;
         overflow_r <= pend_ovf_r;
         for (int k = 0; k < MAX_SLOTS; k++) begin
            act_valid_r[k]  <= pend_valid_r[k];
            act_x_r[k]      <= pend_x_r[k];
            act_pal_r[k]    <= pend_pal_r[k];
            act_hflip_r[k]  <= pend_hflip_r[k];
            act_data_r[k]   <= pend_data_r[k];
            pend_valid_r[k] <= 1'b0;
         end
      end else begin
         if (ovf_set_s) begin
            pend_ovf_r <= 1'b1;
         end
         if (capture_s) begin
            pend_valid_r[slot_s] <= 1'b1;
            pend_x_r[slot_s]     <= attr_x_r[cur_s];
            pend_pal_r[slot_s]   <= attr_pal_r[cur_s];
            pend_hflip_r[slot_s] <= attr_hflip_r[cur_s];
            pend_data_r[slot_s]  <= bus.mem_rdata;
            pend_cnt_r           <= pend_cnt_r + CNT_W'(1'b1);
         end
      end
   end

   // Per-slot pixel lookup; column offset wraps modulo 1024
   always_comb begin
      for (int k = 0; k < MAX_SLOTS; k++) begin
         dx_s[k]     = bus.pix_x - act_x_r[k];
         p_s[k]      = act_hflip_r[k] ? ~dx_s[k][3:0] : dx_s[k][3:0];
         col_s[k]    = act_data_r[k][{p_s[k], 1'b0} +: 2];
         opaque_s[k] = act_valid_r[k] && (dx_s[k][9:4] == 6'd0) && (col_s[k] != 2'd0);
      end
   end

   // Priority select: walking downwards lets the lowest opaque slot win
   always_comb begin
      hit_nx_s   = 1'b0;
      color_nx_s = 2'd0;
      pal_nx_s   = 2'd0;
      for (int k = MAX_SLOTS - 1; k >= 0; k--) begin
         hit_nx_s   = opaque_s[k] ? 1'b1         : hit_nx_s;
         color_nx_s = opaque_s[k] ? col_s[k]     : color_nx_s;
         pal_nx_s   = opaque_s[k] ? act_pal_r[k] : pal_nx_s;
      end
   end

   // Registered pixel outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_hit_r   <= 1'b0;
         pix_color_r <= 2'd0;
         pix_pal_r   <= 2'd0;
      end else begin
         pix_hit_r   <= hit_nx_s;
         pix_color_r <= color_nx_s;
         pix_pal_r   <= pal_nx_s;
      end
   end

   assign bus.mem_raddr = mem_raddr_r;
   assign bus.busy      = busy_r;
   assign bus.overflow  = overflow_r;
   assign bus.pix_hit   = pix_hit_r;
   assign bus.pix_color = pix_color_r;
   assign bus.pix_pal   = pix_pal_r;
endmodule
